// File: rtl/cipher_out_serializer_if.sv
// cipher_out_serializer_if
//   Bundles the ciphertext capture port and the word-stream output of the
//   AES output serializer.
//   master : cipher/feeder + consumer side (drives valid_in, data_in, out_ready)
//   slave  : serializer side (drives out_valid, out_data, out_last,
//            free_blocks, overflow)
interface cipher_out_serializer_if #(
    parameter int DATA_W = 128,
    parameter int WORD_W = 32,
    parameter int DEPTH  = 4
);
    logic                     valid_in;
    logic [DATA_W-1:0]        data_in;
    logic                     out_valid;
    logic                     out_ready;
    logic [WORD_W-1:0]        out_data;
    logic                     out_last;
    logic [$clog2(DEPTH):0]   free_blocks;
    logic                     overflow;

    modport master (
        output valid_in, data_in, out_ready,
        input  out_valid, out_data, out_last, free_blocks, overflow
    );

    modport slave (
        input  valid_in, data_in, out_ready,
        output out_valid, out_data, out_last, free_blocks, overflow
    );
endinterface

// File: rtl/cipher_out_serializer.sv
// cipher_out_serializer
//   Captures 128-bit ciphertext blocks (one-cycle valid pulses from a
//   non-stallable cipher pipeline) into a DEPTH-block FIFO and drains them as
//   WORD_W-bit words, most-significant word first, over valid/ready.
//   Reports free space for feeder throttling and a sticky overflow flag.
// Ports
//   clk    : rising-edge clock
//   reset  : synchronous active-high reset
//   bus    : slave side of cipher_out_serializer_if
//            in  valid_in, data_in, out_ready
//            out out_valid, out_data, out_last, free_blocks, overflow
module cipher_out_serializer #(
    parameter int DATA_W = 128,
    parameter int WORD_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    cipher_out_serializer_if.slave   bus
);
    localparam int NW = DATA_W / WORD_W;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int IW = (NW > 1) ? $clog2(NW) : 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wp;
    logic [AW-1:0]     r_rp;
    logic [CW-1:0]     r_cnt;
    logic [CW-1:0]     r_free;
    logic [IW-1:0]     r_widx;
    logic              r_ovf;

    logic              w_xfer;
    logic              w_last;
    logic              w_pop;
    logic              w_full;
    logic              w_push;
    logic              w_drop;
    logic [CW-1:0]     w_cnt_nxt;
    logic [DATA_W-1:0] w_head;
    logic [WORD_W-1:0] w_words [NW];

    // Head block split into words, word 0 taken from the top bits.
    assign w_head = r_mem[r_rp];
    generate
        for (genvar k = 0; k < NW; k++) begin : g_word
            assign w_words[k] = w_head[DATA_W-1-k*WORD_W -: WORD_W];
        end
    endgenerate

    // Outputs are muxes of registered state only; no path from valid_in/data_in.
    assign bus.out_valid   = (r_cnt != '0);
    assign w_last          = (r_widx == IW'(NW-1));
    assign bus.out_data    = bus.out_valid ? w_words[r_widx] : '0;
    assign bus.out_last    = bus.out_valid & w_last;
    assign bus.free_blocks = r_free;
    assign bus.overflow    = r_ovf;

    assign w_xfer = bus.out_valid & bus.out_ready;
    assign w_pop  = w_xfer & w_last;
    assign w_full = (r_cnt == CW'(DEPTH));
    // A full FIFO still accepts when its head block leaves on the same edge.
    assign w_push = bus.valid_in & (~w_full | w_pop);
    assign w_drop = bus.valid_in & w_full & ~w_pop;

    always_comb begin
        w_cnt_nxt = r_cnt;
        case ({w_push, w_pop})
            2'b10:   w_cnt_nxt = r_cnt + 1'b1;
            2'b01:   w_cnt_nxt = r_cnt - 1'b1;
            default: w_cnt_nxt = r_cnt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wp   <= '0;
            r_rp   <= '0;
            r_cnt  <= '0;
            r_widx <= '0;
            r_ovf  <= 1'b0;
            r_free <= CW'(DEPTH);
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_xfer) begin
                if (w_last) begin
                    r_widx <= '0;
                    r_rp   <= r_rp + 1'b1;
                end else begin
                    r_widx <= r_widx + 1'b1;
                end
            end
            if (w_drop) r_ovf <= 1'b1;
            r_cnt  <= w_cnt_nxt;
            r_free <= CW'(DEPTH) - w_cnt_nxt;
        end
    end

    // Storage needs no reset: slots are only read while counted as occupied.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= bus.data_in;
    end
endmodule

// File: tb/tb_cipher_out_serializer.sv
// tb_cipher_out_serializer
//   Scoreboard bench: every pushed block queues its expected words (with the
//   last flag); a negedge monitor pops and compares on each handshake and
//   also checks stall stability and idle zeroing.
module tb_cipher_out_serializer;
    localparam int DATA_W = 128;
    localparam int WORD_W = 32;
    localparam int DEPTH  = 4;
    localparam int NW     = DATA_W / WORD_W;

    logic clk;
    logic reset;

    cipher_out_serializer_if #(.DATA_W(DATA_W), .WORD_W(WORD_W), .DEPTH(DEPTH)) bus ();

    cipher_out_serializer #(.DATA_W(DATA_W), .WORD_W(WORD_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int n_words = 0;
    logic [WORD_W:0] sbq [$];
    logic            prev_stall = 1'b0;
    logic [WORD_W:0] prev_word  = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one block for one cycle; keep=1 when the block must come out.
    task automatic push(input logic [DATA_W-1:0] blk, input bit keep);
        logic [DATA_W-1:0] b;
        b = blk;
        bus.valid_in = 1'b1;
        bus.data_in  = b;
        if (keep)
            for (int k = 0; k < NW; k++)
                sbq.push_back({(k == NW-1), b[DATA_W-1-k*WORD_W -: WORD_W]});
        tick();
        bus.valid_in = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.valid_in = 1'b0;
        sbq.delete();
        tick();
        tick();
        reset = 1'b0;
    endtask

    // mode 0: ready held high; mode 1: ready pattern 1,0,0,1,...
    task automatic drain(input string tag, input int mode);
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 300) begin
            bus.out_ready = (mode == 0) ? 1'b1 : ((n % 4 == 0) || (n % 4 == 3));
            tick();
            n++;
        end
        bus.out_ready = 1'b0;
        chk({tag, "_drain_done"}, 64'(sbq.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 64'(bus.out_valid), 64'd1);
                chk("stall_data", 64'({bus.out_last, bus.out_data}), 64'(prev_word));
            end
            if (!bus.out_valid)
                chk("idle_zero", 64'({bus.out_last, bus.out_data}), 64'd0);
            if (bus.out_valid && bus.out_ready) begin
                if (sbq.size() == 0) chk("unexpected_word", 64'({bus.out_last, bus.out_data}), 64'd0);
                else chk("word", 64'({bus.out_last, bus.out_data}), 64'(sbq.pop_front()));
                n_words++;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_word  = {bus.out_last, bus.out_data};
        end
    end

    initial begin
        int w0, cyc, sent;
        reset = 1'b1;
        bus.valid_in  = 1'b0;
        bus.data_in   = '0;
        bus.out_ready = 1'b0;
        do_reset();

        // Reset state
        chk("rst_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_data", 64'(bus.out_data), 64'd0);
        chk("rst_last", 64'(bus.out_last), 64'd0);
        chk("rst_free", 64'(bus.free_blocks), 64'd4);
        chk("rst_ovf", 64'(bus.overflow), 64'd0);

        // FIPS-197 C.1 ciphertext
        bus.out_ready = 1'b1;
        push(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b1);
        chk("fips_valid", 64'(bus.out_valid), 64'd1);
        chk("fips_w0", 64'(bus.out_data), 64'h69c4e0d8);
        chk("fips_free3", 64'(bus.free_blocks), 64'd3);
        tick(); tick(); tick();
        chk("fips_last", 64'({bus.out_last, bus.out_data}), {31'd0, 1'b1, 32'h70b4c55a});
        tick();
        chk("fips_done", 64'(sbq.size()), 64'd0);
        chk("fips_free4", 64'(bus.free_blocks), 64'd4);
        bus.out_ready = 1'b0;

        // Backpressure
        push({$urandom, $urandom, $urandom, $urandom}, 1'b1);
        push({$urandom, $urandom, $urandom, $urandom}, 1'b1);
        chk("bp_free2", 64'(bus.free_blocks), 64'd2);
        w0 = n_words;
        drain("bp", 1);
        chk("bp_count", 64'(n_words - w0), 64'd8);
        chk("bp_free4", 64'(bus.free_blocks), 64'd4);

        // Overflow: A..D kept, E dropped
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push({4{32'hA0 + 32'(i)}}, 1'b1);
        chk("ovf_before", 64'(bus.overflow), 64'd0);
        push({4{32'hEEEE_EEEE}}, 1'b0);
        chk("ovf_set", 64'(bus.overflow), 64'd1);
        chk("ovf_free0", 64'(bus.free_blocks), 64'd0);
        drain("ovf", 0);
        chk("ovf_sticky", 64'(bus.overflow), 64'd1);
        chk("ovf_free4", 64'(bus.free_blocks), 64'd4);
        do_reset();
        chk("ovf_cleared", 64'(bus.overflow), 64'd0);

        // Full plus simultaneous pop
        for (int i = 0; i < 4; i++) push({$urandom, $urandom, $urandom, 32'(i)}, 1'b1);
        chk("fp_full", 64'(bus.free_blocks), 64'd0);
        bus.out_ready = 1'b1;
        tick(); tick(); tick();
        chk("fp_at_last", 64'(bus.out_last), 64'd1);
        push({4{32'hF00D_0004}}, 1'b1);
        chk("fp_free0", 64'(bus.free_blocks), 64'd0);
        chk("fp_no_ovf", 64'(bus.overflow), 64'd0);
        drain("fp", 0);
        chk("fp_ovf_end", 64'(bus.overflow), 64'd0);

        // Wrap-around with random gaps and random ready
        w0 = n_words;
        sent = 0;
        cyc = 0;
        while ((sent < 10 || sbq.size() != 0) && cyc < 3000) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            if (sent < 10 && bus.free_blocks != 0 && $urandom_range(0, 2) == 0) begin
                push({$urandom, $urandom, $urandom, $urandom}, 1'b1);
                sent++;
            end else begin
                tick();
            end
            cyc++;
        end
        bus.out_ready = 1'b0;
        chk("wrap_done", 64'(sbq.size()), 64'd0);
        chk("wrap_count", 64'(n_words - w0), 64'd40);
        chk("wrap_ovf", 64'(bus.overflow), 64'd0);

        // Reset mid-block
        bus.out_ready = 1'b1;
        push(128'h11111111_22222222_33333333_44444444, 1'b1);
        tick(); tick();
        chk("mr_word2", 64'(bus.out_data), 64'h33333333);
        reset = 1'b1;
        sbq.delete();
        tick();
        reset = 1'b0;
        chk("mr_valid", 64'(bus.out_valid), 64'd0);
        chk("mr_free", 64'(bus.free_blocks), 64'd4);
        bus.out_ready = 1'b0;
        push(128'h55555555_66666666_77777777_88888888, 1'b1);
        chk("mr_new_w0", 64'(bus.out_data), 64'h55555555);
        drain("mr", 0);
        chk("mr_free_end", 64'(bus.free_blocks), 64'd4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/cipher_out_serializer.md
# cipher_out_serializer

Downstream stage of the pipelined AES-128 cipher. It captures each 128-bit ciphertext block that the cipher emits with a one-cycle valid pulse and buffers it in a small FIFO. It then drains the blocks as WORD_W-bit words over a valid/ready handshake. The cipher pipeline cannot be stalled, so the block also reports free space so the feeder can throttle `data_valid_in`, and it flags any block lost to overflow.

## Interface
Parameters:
- DATA_W, 128, ciphertext block width
- WORD_W, 32, output word width; DATA_W must be an integer multiple of it; NW = DATA_W/WORD_W words per block
- DEPTH, 4, FIFO depth in blocks; power of two, ≥2

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- valid_in  in  1  one-cycle pulse: data_in holds a ciphertext block (driven by cipher valid_out)
- data_in  in  DATA_W  ciphertext block (driven by cipher_text)
- out_valid  out  1  out_data holds a valid word
- out_ready  in  1  consumer accepts the word this cycle
- out_data  out  WORD_W  current output word
- out_last  out  1  current word is the final word of its block
- free_blocks  out  $clog2(DEPTH)+1  DEPTH − stored block count
- overflow  out  1  sticky; a block was dropped

## Operation
- Storage: DEPTH×DATA_W array with write pointer wp, read pointer rp (log2 DEPTH bits, wrap modulo DEPTH), block count cnt (0..DEPTH), and word index widx (0..NW−1) into the head block.
- Word order: most-significant word first. Word k of a block is data[DATA_W−1−k·WORD_W −: WORD_W], matching FIPS-197 byte order.
- Handshake: a word transfers when out_valid && out_ready. out_valid = (cnt≠0). While out_valid is high, out_data and out_last hold stable until the transfer. When out_valid is low, out_data = 0 and out_last = 0.
- Transfer effects:
  - If widx < NW−1: widx increments.
  - If widx = NW−1 (out_last = 1): this is a pop. widx→0, rp increments, and the slot is freed.
- Push: on valid_in, accepted if cnt < DEPTH, or if cnt = DEPTH and a pop happens the same cycle. An accepted push writes mem[wp] and increments wp.
- Drop: on valid_in with cnt = DEPTH and no pop, the block is discarded, overflow←1 (stays set until reset), and no state changes.
- Count update: cnt changes by +1 on push only, −1 on pop only, and is unchanged on simultaneous push and pop.
- free_blocks = DEPTH − cnt, registered from the updated cnt.
- No combinational path from valid_in or data_in to any output. out_ready → outputs is registered only; out_data may be a mux of registered state.

## Timing
- Reset: cnt = 0, wp = rp = 0, widx = 0, overflow = 0. Outputs after reset: out_valid = 0, out_data = 0, out_last = 0, free_blocks = DEPTH. Memory contents are don't-care.
- Push latency: valid_in at edge N gives out_valid = 1 and word 0 visible after edge N, and free_blocks drops by 1 after edge N.
- Minimum drain time: NW cycles per block with out_ready held high. Back-to-back blocks stream with no bubble; word 0 of the next block follows out_last directly.
- Reset mid-block: all pending words and blocks are discarded. The next push after reset is emitted from word 0.
- Boundary rules:
  - Push into an empty FIFO: output appears the cycle after the push.
  - Push at full with a simultaneous pop: accepted, cnt stays DEPTH, no overflow.
  - Pointer wrap: wp and rp wrap modulo DEPTH with no special case.
- Feeder rule (informative): with cipher latency L, the feeder issues a new block only when free_blocks exceeds the number of blocks in flight.

## Test plan
- FIPS-197 C.1 vector: one valid_in with data_in = 69c4e0d86a7b0430d8cdb78070b4c55a, out_ready = 1. Required: words 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a on 4 consecutive cycles starting one cycle after the push; out_last only on 70b4c55a; free_blocks 4→3→4.
- Backpressure: 2 blocks pushed on consecutive cycles, out_ready toggled 1,0,0,1,…. Required: out_data stable while stalled, no word skipped or duplicated, 8 words in order, free_blocks returns to 4.
- Overflow: out_ready = 0, 5 pushes of blocks A..E. Required: cnt = 4, free_blocks = 0, overflow = 1 from the cycle after E. Draining then yields A..D only; overflow stays 1.
- Full plus simultaneous pop: FIFO full, out_ready = 1 at the out_last word, valid_in pulsed the same cycle. Required: block accepted, overflow stays 0, free_blocks stays 0, the new block is emitted after the 3 older ones.
- Wrap-around: 10 blocks with random gaps and random out_ready. Required: output sequence equals input sequence exactly, 40 words, overflow = 0 (feeder obeys free_blocks).
- Reset mid-block: reset asserted after word 1 of a block. Required: the next cycle shows out_valid = 0 and free_blocks = 4. A new block pushed afterwards starts at its word 0.
